op_select_sequencer: RTL

OP_SELECT_SEQUENCER -- requirements
Module: op_select_sequencer

---
 rtl/tabla_opsel_pkg.sv | 39 +++
 rtl/opsel_prog_mem.sv | 30 +++
 rtl/op_select_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tabla_opsel_pkg.sv
// Shared definitions for the operand-select sequencer: selector codes,
// program entry layout, and the control state encoding.
package tabla_opsel_pkg;

  localparam int SEL_W   = 3;
  localparam int ENTRY_W = 7;

  // Operand source selected for the datapath's A and B inputs.
  typedef enum logic [SEL_W-1:0] {
    SEL_ZERO     = 3'd0,
    SEL_WEIGHT   = 3'd1,
    SEL_DATA     = 3'd2,
    SEL_GRADIENT = 3'd3,
    SEL_INTERIM  = 3'd4,
    SEL_META     = 3'd5,
    SEL_NEIGH    = 3'd6,
    SEL_BUS      = 3'd7
  } sel_t;

  // One program entry: {last[6], sel_b[5:3], sel_a[2:0]}.
  typedef struct packed {
    logic last;
    sel_t sel_b;
    sel_t sel_a;
  } entry_t;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when either selector of the entry names the given source.
  function automatic logic needs_src(entry_t e, sel_t code);
    return (e.sel_a == code) || (e.sel_b == code);
  endfunction

endpackage

// File: rtl/opsel_prog_mem.sv
// Program storage for the sequencer: DEPTH entries, synchronous write,
// combinational read so the entry at pc is visible in the same cycle.
module opsel_prog_mem
  import tabla_opsel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Store a program word on a qualified write strobe.
  // NOTE: the array has no reset on purpose; a loaded program must survive
  // a reset pulse, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/op_select_sequencer.sv
// Operand-select sequencer: steps through a small program of selector
// pairs, issuing one pair per cycle once the external operands it needs
// (bus and/or neighbour) are available, and acknowledging those operands.
module op_select_sequencer
  import tabla_opsel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [ENTRY_W-1:0] prog_data,
  input  logic               start,
  input  logic               bus_valid,
  input  logic               neigh_valid,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic               issue,
  output logic               bus_ack,
  output logic               neigh_ack,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(DEPTH - 1);

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ENTRY_W-1:0] rd_word;
  entry_t             entry;
  logic               mem_we;
  logic               need_bus;
  logic               need_neigh;
  logic               ready;
  logic               is_final;

  // The program may only be altered while no run is in progress.
  assign mem_we = prog_we && (state == S_IDLE);

  opsel_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_mem (
    .clk     (clk),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_addr (pc),
    .rd_data (rd_word)
  );

  // Decode the current entry: which external sources it waits on, and
  // whether issuing it ends the program (explicit last or end of memory).
  assign entry      = entry_t'(rd_word);
  assign need_bus   = needs_src(entry, SEL_BUS);
  assign need_neigh = needs_src(entry, SEL_NEIGH);
  assign ready      = (!need_bus || bus_valid) && (!need_neigh || neigh_valid);
  assign is_final   = entry.last || (pc == LAST_PC);

  // Control FSM with all outputs registered; issue and acks are one-cycle
  // strobes that default low and are raised only when an entry goes out.
  // NOTE: every assignment here is non-blocking so that all registers
  // update together from the values present before the clock edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      pc        <= '0;
      sel_a     <= '0;
      sel_b     <= '0;
      issue     <= 1'b0;
      bus_ack   <= 1'b0;
      neigh_ack <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      issue     <= 1'b0;
      bus_ack   <= 1'b0;
      neigh_ack <= 1'b0;
      done      <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pc    <= '0;
            busy  <= 1'b1;
          end
        end

        S_RUN: begin
          // A stalled entry leaves pc and the selector registers untouched.
          if (ready) begin
            sel_a     <= entry.sel_a;
            sel_b     <= entry.sel_b;
            issue     <= 1'b1;
            bus_ack   <= need_bus;
            neigh_ack <= need_neigh;
            if (is_final) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
